compress_fifo_mp: RTL and testbench

Parametrised multi-port compressing FIFO, the successor to the fixed 2-in/2-out compress FIFO. Each cycle it accepts 0..WRITE_PORT densely packed entries and releases 0..READ_PORT entries in order. It sits between the fetch/predecode stage and the decode/issue stage, where per-cycle instruction counts vary. It adds arbitrary port counts, a correctly sized occupancy counter, a registered occupancy output, same-cycle write-to-read visibility, read-count clamping, and a fully reset handshake.

---
 rtl/compress_fifo_mp.sv | 126 ++++++++++++
 tb/tb_compress_fifo_mp.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_fifo_mp.sv
// Multi-port compressing FIFO: accepts 0..WRITE_PORT densely packed entries
// and releases 0..READ_PORT entries per cycle, in order. All handshake and
// data outputs are registered and computed from the next state, so entries
// written this cycle are already visible on the read lanes next cycle.
module compress_fifo_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WRITE_PORT = 4,
  parameter int READ_PORT  = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic                                  write_valid_i,
  output logic                                  write_ready_o,
  input  logic [$clog2(WRITE_PORT + 1)-1:0]     write_num_i,
  input  logic [WRITE_PORT*DATA_WIDTH-1:0]      write_data_i,
  output logic [READ_PORT-1:0]                  read_valid_o,
  input  logic                                  read_ready_i,
  input  logic [$clog2(READ_PORT + 1)-1:0]      read_num_i,
  output logic [READ_PORT*DATA_WIDTH-1:0]       read_data_o,
  output logic [CNT_W-1:0]                      count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WN_W  = $clog2(WRITE_PORT + 1);

  // Storage is deliberately not reset; validity is tracked by the count.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0]      wptr_r;
  logic [PTR_W-1:0]      rptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  wr_acc_s;
  logic [CNT_W-1:0]      wn_acc_s;
  logic [CNT_W-1:0]      rn_ext_s;
  logic [CNT_W-1:0]      eff_s;
  logic [CNT_W-1:0]      count_next_s;
  logic [CNT_W-1:0]      free_next_s;
  logic [PTR_W-1:0]      wptr_next_s;
  logic [PTR_W-1:0]      rptr_next_s;
  logic                  wr_ready_next_s;
  logic [READ_PORT-1:0]  rd_valid_next_s;

  logic [WRITE_PORT-1:0] wr_lane_en_s;
  logic [DATA_WIDTH-1:0] wr_lane_s     [WRITE_PORT];
  logic [PTR_W-1:0]      wr_idx_s      [WRITE_PORT];
  logic [PTR_W-1:0]      rd_idx_s      [READ_PORT];
  logic [DATA_WIDTH-1:0] rd_data_next_s [READ_PORT];

  assign count_o = count_r;

  // Accepted write/read amounts, next pointers, next occupancy and flags.
  always_comb begin
    wr_acc_s     = write_valid_i & write_ready_o & ~flush_i & ~rst;
    wn_acc_s     = wr_acc_s ? CNT_W'(write_num_i) : {CNT_W{1'b0}};
    rn_ext_s     = CNT_W'(read_num_i);
    // A pop never removes more than is present, so the count cannot underflow.
    eff_s        = (read_ready_i & ~flush_i)
                   ? ((rn_ext_s < count_r) ? rn_ext_s : count_r)
                   : {CNT_W{1'b0}};
    count_next_s = flush_i ? {CNT_W{1'b0}} : (count_r + wn_acc_s - eff_s);
    wptr_next_s  = flush_i ? {PTR_W{1'b0}} : (wptr_r + PTR_W'(wn_acc_s));
    rptr_next_s  = flush_i ? {PTR_W{1'b0}} : (rptr_r + PTR_W'(eff_s));
    free_next_s  = CNT_W'(DEPTH) - count_next_s;
    // Ready only when a full-width write is guaranteed to fit next cycle.
    wr_ready_next_s = (free_next_s >= CNT_W'(WRITE_PORT));
    for (int i = 0; i < READ_PORT; i++) begin
      rd_valid_next_s[i] = (count_next_s > CNT_W'(i));
    end
  end

  // Unpack write lanes and compute their target slots.
  always_comb begin
    for (int j = 0; j < WRITE_PORT; j++) begin
      wr_lane_s[j]    = write_data_i[j*DATA_WIDTH +: DATA_WIDTH];
      wr_idx_s[j]     = wptr_r + PTR_W'(j);
      wr_lane_en_s[j] = wr_acc_s & (WN_W'(j) < write_num_i);
    end
  end

  // Next read-lane data, bypassing entries that are being written this cycle.
  always_comb begin
    for (int i = 0; i < READ_PORT; i++) begin
      rd_idx_s[i]       = rptr_next_s + PTR_W'(i);
      rd_data_next_s[i] = mem_r[rd_idx_s[i]];
      for (int j = 0; j < WRITE_PORT; j++) begin
        rd_data_next_s[i] = (wr_lane_en_s[j] && (wr_idx_s[j] == rd_idx_s[i]))
                            ? wr_lane_s[j] : rd_data_next_s[i];
      end
    end
  end

  // Store accepted write lanes into the circular array.
  always_ff @(posedge clk) begin
    for (int j = 0; j < WRITE_PORT; j++) begin
      if (wr_lane_en_s[j]) begin
        mem_r[wr_idx_s[j]] <= wr_lane_s[j];
      end
    end
  end

  // Pointer, occupancy and registered output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r        <= {PTR_W{1'b0}};
      rptr_r        <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      write_ready_o <= 1'b1;
      read_valid_o  <= {READ_PORT{1'b0}};
      read_data_o   <= {(READ_PORT*DATA_WIDTH){1'b0}};
    end else begin
      wptr_r        <= wptr_next_s;
      rptr_r        <= rptr_next_s;
      count_r       <= count_next_s;
      write_ready_o <= wr_ready_next_s;
      read_valid_o  <= rd_valid_next_s;
      for (int i = 0; i < READ_PORT; i++) begin
        read_data_o[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data_next_s[i];
      end
    end
  end

endmodule

// File: tb/tb_compress_fifo_mp.sv
// Directed self-checking bench for compress_fifo_mp with default parameters.
module tb_compress_fifo_mp;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic         write_valid_i;
  logic         write_ready_o;
  logic [2:0]   write_num_i;
  logic [127:0] write_data_i;
  logic [1:0]   read_valid_o;
  logic         read_ready_i;
  logic [1:0]   read_num_i;
  logic [63:0]  read_data_o;
  logic [4:0]   count_o;

  int checks;
  int errors;

  compress_fifo_mp dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .write_valid_i (write_valid_i),
    .write_ready_o (write_ready_o),
    .write_num_i   (write_num_i),
    .write_data_i  (write_data_i),
    .read_valid_o  (read_valid_o),
    .read_ready_i  (read_ready_i),
    .read_num_i    (read_num_i),
    .read_data_o   (read_data_o),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_valid_i = 1'b0;
    write_num_i   = 3'd0;
    write_data_i  = 128'd0;
    read_ready_i  = 1'b0;
    read_num_i    = 2'd0;
    flush_i       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (write_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", write_ready_o); end
    checks++;
    if (read_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", read_valid_o); end
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++;
    if (read_data_o !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", read_data_o); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_pass_through();
    write_valid_i = 1'b1;
    write_num_i   = 3'd3;
    write_data_i  = {32'hDEAD, 32'hA2, 32'hA1, 32'hA0};
    cyc();
    idle();
    checks++;
    if (read_valid_o !== 2'b11) begin errors++; $display("FAIL pt_valid got %b want 11", read_valid_o); end
    checks++;
    if (read_data_o !== {32'hA1, 32'hA0}) begin errors++; $display("FAIL pt_lanes got %h want a1/a0", read_data_o); end
    checks++;
    if (count_o !== 5'd3) begin errors++; $display("FAIL pt_count got %0d want 3", count_o); end
    read_ready_i = 1'b1;
    read_num_i   = 2'd2;
    cyc();
    idle();
    checks++;
    if (read_valid_o !== 2'b01) begin errors++; $display("FAIL pt_pop_valid got %b want 01", read_valid_o); end
    checks++;
    if (read_data_o[31:0] !== 32'hA2) begin errors++; $display("FAIL pt_pop_lane0 got %h want a2", read_data_o[31:0]); end
    checks++;
    if (count_o !== 5'd1) begin errors++; $display("FAIL pt_pop_count got %0d want 1", count_o); end
    read_ready_i = 1'b1;
    read_num_i   = 2'd1;
    cyc();
    idle();
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL pt_drain got %0d want 0", count_o); end
  endtask

  task automatic test_full();
    logic [4:0] want_cnt;
    for (int k = 0; k < 4; k++) begin
      write_valid_i = 1'b1;
      write_num_i   = 3'd4;
      write_data_i  = {32'h103 + 32'(4*k), 32'h102 + 32'(4*k), 32'h101 + 32'(4*k), 32'h100 + 32'(4*k)};
      cyc();
      want_cnt = 5'(4*(k+1));
      checks++;
      if (count_o !== want_cnt) begin errors++; $display("FAIL full_fill%0d_count got %0d want %0d", k, count_o, want_cnt); end
      checks++;
      if (write_ready_o !== (k < 3)) begin errors++; $display("FAIL full_fill%0d_ready got %b want %b", k, write_ready_o, (k < 3)); end
    end
    // Still requesting while not ready: nothing may change.
    write_data_i = {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'hBAD0};
    cyc();
    checks++;
    if (count_o !== 5'd16) begin errors++; $display("FAIL full_hold_count got %0d want 16", count_o); end
    checks++;
    if (read_data_o !== {32'h101, 32'h100}) begin errors++; $display("FAIL full_hold_data got %h want 101/100", read_data_o); end
    read_ready_i = 1'b1;
    read_num_i   = 2'd2;
    cyc();
    checks++;
    if (count_o !== 5'd14) begin errors++; $display("FAIL full_pop1_count got %0d want 14", count_o); end
    checks++;
    if (write_ready_o !== 1'b0) begin errors++; $display("FAIL full_pop1_ready got %b want 0", write_ready_o); end
    checks++;
    if (read_data_o[31:0] !== 32'h102) begin errors++; $display("FAIL full_pop1_head got %h want 102", read_data_o[31:0]); end
    cyc();
    checks++;
    if (count_o !== 5'd12) begin errors++; $display("FAIL full_pop2_count got %0d want 12", count_o); end
    checks++;
    if (write_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop2_ready got %b want 1", write_ready_o); end
    checks++;
    if (read_data_o[31:0] !== 32'h104) begin errors++; $display("FAIL full_pop2_head got %h want 104", read_data_o[31:0]); end
    write_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    idle();
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL full_drain got %0d want 0", count_o); end
  endtask

  task automatic test_wrap_stream();
    int wpat [4];
    int rpat [4];
    int next_w;
    int exp_pop;
    int mcnt;
    int wn;
    int rn;
    int eff;
    int cycle;
    logic acc;
    wpat = '{1, 3, 4, 2};
    rpat = '{2, 1, 2, 0};
    next_w  = 0;
    exp_pop = 0;
    mcnt    = 0;
    cycle   = 0;
    while (exp_pop < 64 && cycle < 400) begin
      checks++;
      if (count_o !== 5'(mcnt)) begin errors++; $display("FAIL stream_count c%0d got %0d want %0d", cycle, count_o, mcnt); end
      checks++;
      if (write_ready_o !== ((16 - mcnt) >= 4)) begin errors++; $display("FAIL stream_ready c%0d got %b want %b", cycle, write_ready_o, ((16 - mcnt) >= 4)); end
      if (mcnt > 0) begin
        checks++;
        if (read_data_o[31:0] !== 32'(exp_pop)) begin errors++; $display("FAIL stream_lane0 c%0d got %0d want %0d", cycle, read_data_o[31:0], exp_pop); end
      end
      if (mcnt > 1) begin
        checks++;
        if (read_data_o[63:32] !== 32'(exp_pop + 1)) begin errors++; $display("FAIL stream_lane1 c%0d got %0d want %0d", cycle, read_data_o[63:32], exp_pop + 1); end
      end
      wn = (64 - next_w < wpat[cycle % 4]) ? (64 - next_w) : wpat[cycle % 4];
      write_valid_i = (wn > 0);
      write_num_i   = 3'(wn);
      for (int j = 0; j < 4; j++) write_data_i[j*32 +: 32] = 32'(next_w + j);
      acc = (wn > 0) && ((16 - mcnt) >= 4);
      rn  = rpat[cycle % 4];
      read_ready_i = 1'b1;
      read_num_i   = 2'(rn);
      eff = (rn < mcnt) ? rn : mcnt;
      cyc();
      if (acc) begin
        next_w = next_w + wn;
        mcnt   = mcnt + wn;
      end
      mcnt    = mcnt - eff;
      exp_pop = exp_pop + eff;
      cycle++;
    end
    idle();
    checks++;
    if (exp_pop !== 64) begin errors++; $display("FAIL stream_timeout popped %0d want 64", exp_pop); end
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL stream_end_count got %0d want 0", count_o); end
  endtask

  task automatic test_simul_clamp();
    write_valid_i = 1'b1;
    write_num_i   = 3'd1;
    write_data_i  = {96'd0, 32'h5};
    cyc();
    checks++;
    if (count_o !== 5'd1) begin errors++; $display("FAIL sc_setup got %0d want 1", count_o); end
    write_num_i  = 3'd2;
    write_data_i = {64'd0, 32'h7, 32'h6};
    read_ready_i = 1'b1;
    read_num_i   = 2'd2;
    cyc();
    write_valid_i = 1'b0;
    checks++;
    if (count_o !== 5'd2) begin errors++; $display("FAIL sc_count got %0d want 2", count_o); end
    checks++;
    if (read_data_o !== {32'h7, 32'h6}) begin errors++; $display("FAIL sc_lanes got %h want 7/6", read_data_o); end
    checks++;
    if (read_valid_o !== 2'b11) begin errors++; $display("FAIL sc_valid got %b want 11", read_valid_o); end
    cyc();
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL sc_drain got %0d want 0", count_o); end
    cyc();
    idle();
    checks++;
    if (count_o !== 5'd0 || read_valid_o !== 2'b00) begin errors++; $display("FAIL sc_empty_pop got %0d/%b want 0/00", count_o, read_valid_o); end
  endtask

  task automatic test_flush();
    write_valid_i = 1'b1;
    write_num_i   = 3'd4;
    write_data_i  = {32'h13, 32'h12, 32'h11, 32'h10};
    cyc();
    cyc();
    write_num_i = 3'd2;
    cyc();
    checks++;
    if (count_o !== 5'd10) begin errors++; $display("FAIL fl_setup got %0d want 10", count_o); end
    flush_i      = 1'b1;
    write_num_i  = 3'd4;
    read_ready_i = 1'b1;
    read_num_i   = 2'd2;
    cyc();
    idle();
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL fl_count got %0d want 0", count_o); end
    checks++;
    if (read_valid_o !== 2'b00) begin errors++; $display("FAIL fl_valid got %b want 00", read_valid_o); end
    checks++;
    if (write_ready_o !== 1'b1) begin errors++; $display("FAIL fl_ready got %b want 1", write_ready_o); end
    write_valid_i = 1'b1;
    write_num_i   = 3'd1;
    write_data_i  = {96'd0, 32'h1};
    cyc();
    idle();
    checks++;
    if (read_valid_o !== 2'b01 || read_data_o[31:0] !== 32'h1) begin errors++; $display("FAIL fl_readback got %b/%h want 01/1", read_valid_o, read_data_o[31:0]); end
    read_ready_i = 1'b1;
    read_num_i   = 2'd1;
    cyc();
    idle();
  endtask

  task automatic test_reset_midstream();
    write_valid_i = 1'b1;
    write_num_i   = 3'd3;
    write_data_i  = {32'h0, 32'h33, 32'h32, 32'h31};
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    checks++;
    if (count_o !== 5'd0 || read_valid_o !== 2'b00) begin errors++; $display("FAIL rm_empty got %0d/%b want 0/00", count_o, read_valid_o); end
    write_valid_i = 1'b1;
    write_num_i   = 3'd1;
    write_data_i  = {96'd0, 32'h9};
    cyc();
    idle();
    checks++;
    if (count_o !== 5'd1 || read_data_o[31:0] !== 32'h9) begin errors++; $display("FAIL rm_readback got %0d/%h want 1/9", count_o, read_data_o[31:0]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_pass_through();
    test_full();
    test_wrap_stream();
    test_simul_clamp();
    test_flush();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
